// File: rtl/packet_tx_if.sv
// Packet-side and bit-side signal bundle for packet_tx.
// master: transaction engine plus line layer; slave: the packet transmitter.
interface packet_tx_if;
    logic        tx_packet_start;
    logic [3:0]  tx_packet_pid;
    logic [10:0] tx_packet_addr;
    logic [9:0]  tx_packet_len;
    logic [7:0]  tx_packet_byte;
    logic        tx_packet_byte_valid;
    logic        tx_packet_byte_ready;
    logic        tx_bit_req;
    logic        tx_bit;
    logic        tx_start;
    logic        tx_finish;
    logic        tx_busy;
    logic        tx_underrun;

    modport master (
        output tx_packet_start, tx_packet_pid, tx_packet_addr, tx_packet_len,
               tx_packet_byte, tx_packet_byte_valid, tx_bit_req,
        input  tx_packet_byte_ready, tx_bit, tx_start, tx_finish, tx_busy, tx_underrun
    );

    modport slave (
        input  tx_packet_start, tx_packet_pid, tx_packet_addr, tx_packet_len,
               tx_packet_byte, tx_packet_byte_valid, tx_bit_req,
        output tx_packet_byte_ready, tx_bit, tx_start, tx_finish, tx_busy, tx_underrun
    );
endinterface

// File: rtl/packet_tx.sv
// USB full-speed packet transmitter: builds PID, token field or payload, CRC5/CRC16 and shifts it out LSB first.
// Define PACKET_TX_SYNC_EN to emit the 8-bit SYNC pattern ahead of the PID.
module packet_tx (
    input  logic       clk,
    input  logic       rst_n,
    packet_tx_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for tx_packet_start
    // SYNC  | sending SYNC pattern (PACKET_TX_SYNC_EN only)
    // PID   | sending {~pid, pid}
    // FIELD | sending 11-bit token field
    // DATA  | sending payload bytes
    // CRC5  | sending inverted CRC5, MSB first
    // CRC16 | sending inverted CRC16, MSB first
    // DONE  | tx_finish cycle, then back to IDLE
    localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef PACKET_TX_SYNC_EN
    localparam logic [2:0] S_SYNC  = 3'd1;
`endif
    localparam logic [2:0] S_PID   = 3'd2;
    localparam logic [2:0] S_FIELD = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_CRC5  = 3'd5;
    localparam logic [2:0] S_CRC16 = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic [15:0] shreg;
    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic [10:0] field;
    logic [9:0]  bytes_left;
    logic [9:0]  fetch_left;
    logic [7:0]  hold;
    logic        hold_full;
    logic        data_empty;
    logic        is_token;
    logic        is_data;
    logic        start_pulse;
    logic        finish_pulse;
    logic        underrun_pulse;
`ifdef PACKET_TX_SYNC_EN
    logic [7:0]  pid_byte;
`endif

    logic        cur_bit;
    logic        accept;
    logic        fetch;
    logic        new_token;
    logic        new_data;
    logic [4:0]  crc5_next;
    logic [15:0] crc16_next;

    function automatic logic [15:0] crc5_out(input logic [4:0] c);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) r[i] = ~c[4-i];
        return r;
    endfunction

    function automatic logic [15:0] crc16_out(input logic [15:0] c);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = ~c[15-i];
        return r;
    endfunction

    assign cur_bit    = shreg[0];
    assign crc5_next  = {crc5[3:0], 1'b0} ^ ((cur_bit ^ crc5[4]) ? 5'b00101 : 5'b00000);
    assign crc16_next = {crc16[14:0], 1'b0} ^ ((cur_bit ^ crc16[15]) ? 16'h8005 : 16'h0000);
    assign new_token  = (bus.tx_packet_pid[1:0] == 2'b01) || (bus.tx_packet_pid == 4'b0100);
    assign new_data   = (bus.tx_packet_pid[1:0] == 2'b11);
    assign accept     = bus.tx_packet_start && (state == S_IDLE);

    // Prefetch only while the packet can still use a byte; after an underrun DONE closes the window.
    assign bus.tx_packet_byte_ready = !hold_full && (fetch_left != 10'd0) &&
                                      ((state == S_PID) || (state == S_DATA));
    assign fetch           = bus.tx_packet_byte_valid && bus.tx_packet_byte_ready;
    assign bus.tx_bit      = shreg[0];
    assign bus.tx_busy     = (state != S_IDLE);
    assign bus.tx_start    = start_pulse;
    assign bus.tx_finish   = finish_pulse;
    assign bus.tx_underrun = underrun_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            shreg          <= '0;
            crc5           <= 5'h1F;
            crc16          <= 16'hFFFF;
            field          <= '0;
            bytes_left     <= '0;
            fetch_left     <= '0;
            hold           <= '0;
            hold_full      <= 1'b0;
            data_empty     <= 1'b0;
            is_token       <= 1'b0;
            is_data        <= 1'b0;
            start_pulse    <= 1'b0;
            finish_pulse   <= 1'b0;
            underrun_pulse <= 1'b0;
`ifdef PACKET_TX_SYNC_EN
            pid_byte       <= '0;
`endif
        end else begin
            start_pulse    <= 1'b0;
            finish_pulse   <= 1'b0;
            underrun_pulse <= 1'b0;

            if (fetch) begin
                hold       <= bus.tx_packet_byte;
                hold_full  <= 1'b1;
                fetch_left <= fetch_left - 10'd1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        start_pulse <= 1'b1;
                        is_token    <= new_token;
                        is_data     <= new_data;
                        field       <= bus.tx_packet_addr;
                        bytes_left  <= bus.tx_packet_len;
                        fetch_left  <= new_data ? bus.tx_packet_len : 10'd0;
                        crc5        <= 5'h1F;
                        crc16       <= 16'hFFFF;
                        cnt         <= '0;
                        hold_full   <= 1'b0;
                        data_empty  <= 1'b0;
`ifdef PACKET_TX_SYNC_EN
                        pid_byte    <= {~bus.tx_packet_pid, bus.tx_packet_pid};
                        shreg       <= 16'h0080;
                        state       <= S_SYNC;
`else
                        shreg       <= {8'h00, ~bus.tx_packet_pid, bus.tx_packet_pid};
                        state       <= S_PID;
`endif
                    end
                end
`ifdef PACKET_TX_SYNC_EN
                S_SYNC: begin
                    if (bus.tx_bit_req) begin
                        if (cnt == 4'd7) begin
                            cnt   <= '0;
                            shreg <= {8'h00, pid_byte};
                            state <= S_PID;
                        end else begin
                            cnt   <= cnt + 4'd1;
                            shreg <= {1'b0, shreg[15:1]};
                        end
                    end
                end
`endif
                S_PID: begin
                    if (bus.tx_bit_req) begin
                        if (cnt == 4'd7) begin
                            cnt <= '0;
                            if (is_token) begin
                                shreg <= {5'b00000, field};
                                state <= S_FIELD;
                            end else if (is_data && (bytes_left != 10'd0)) begin
                                state <= S_DATA;
                                if (hold_full) begin
                                    shreg     <= {8'h00, hold};
                                    hold_full <= 1'b0;
                                end else begin
                                    shreg      <= '0;
                                    data_empty <= 1'b1;
                                end
                            end else if (is_data) begin
                                shreg <= crc16_out(crc16);
                                state <= S_CRC16;
                            end else begin
                                shreg        <= '0;
                                finish_pulse <= 1'b1;
                                state        <= S_DONE;
                            end
                        end else begin
                            cnt   <= cnt + 4'd1;
                            shreg <= {1'b0, shreg[15:1]};
                        end
                    end
                end
                S_FIELD: begin
                    if (bus.tx_bit_req) begin
                        crc5 <= crc5_next;
                        if (cnt == 4'd10) begin
                            cnt   <= '0;
                            shreg <= crc5_out(crc5_next);
                            state <= S_CRC5;
                        end else begin
                            cnt   <= cnt + 4'd1;
                            shreg <= {1'b0, shreg[15:1]};
                        end
                    end
                end
                S_DATA: begin
                    if (bus.tx_bit_req) begin
                        if (data_empty) begin
                            // line asked for a payload bit that never arrived
                            underrun_pulse <= 1'b1;
                            finish_pulse   <= 1'b1;
                            fetch_left     <= '0;
                            shreg          <= '0;
                            state          <= S_DONE;
                        end else begin
                            crc16 <= crc16_next;
                            if (cnt == 4'd7) begin
                                cnt        <= '0;
                                bytes_left <= bytes_left - 10'd1;
                                if (bytes_left == 10'd1) begin
                                    shreg <= crc16_out(crc16_next);
                                    state <= S_CRC16;
                                end else if (hold_full) begin
                                    shreg     <= {8'h00, hold};
                                    hold_full <= 1'b0;
                                end else begin
                                    shreg      <= '0;
                                    data_empty <= 1'b1;
                                end
                            end else begin
                                cnt   <= cnt + 4'd1;
                                shreg <= {1'b0, shreg[15:1]};
                            end
                        end
                    end else if (data_empty && hold_full) begin
                        shreg      <= {8'h00, hold};
                        hold_full  <= 1'b0;
                        data_empty <= 1'b0;
                    end
                end
                S_CRC5: begin
                    if (bus.tx_bit_req) begin
                        if (cnt == 4'd4) begin
                            shreg        <= '0;
                            finish_pulse <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            cnt   <= cnt + 4'd1;
                            shreg <= {1'b0, shreg[15:1]};
                        end
                    end
                end
                S_CRC16: begin
                    if (bus.tx_bit_req) begin
                        if (cnt == 4'd15) begin
                            shreg        <= '0;
                            finish_pulse <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            cnt   <= cnt + 4'd1;
                            shreg <= {1'b0, shreg[15:1]};
                        end
                    end
                end
                S_DONE: begin
                    cnt        <= '0;
                    hold_full  <= 1'b0;
                    data_empty <= 1'b0;
                    fetch_left <= '0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_tx.sv
// Scoreboard bench for packet_tx: expected bit streams are queued by the stimulus, a monitor pops them on each bit request.
`timescale 1ns/1ps
module tb_packet_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    packet_tx_if pif ();
    packet_tx dut (.clk(clk), .rst_n(rst_n), .bus(pif.slave));

    int pass_cnt = 0;
    int total_cnt = 0;
    bit exp_q[$];
    bit obs_q[$];
    logic [7:0] byte_q[$];
    logic [7:0] pay_q[$];
    bit chk_en = 1'b0;
    bit xfer;
    int start_cnt = 0, fin_cnt = 0, und_cnt = 0, rdy_cnt = 0, hs_cnt = 0;
    int f0, s0, h0, u0, r0;

    task automatic check(input string name, input longint actual, input longint expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    function automatic logic [4:0] crc5_upd(input logic [4:0] c, input bit b);
        return {c[3:0], 1'b0} ^ ((b ^ c[4]) ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input bit b);
        return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (pif.tx_start) start_cnt++;
            if (pif.tx_finish) fin_cnt++;
            if (pif.tx_underrun) und_cnt++;
            if (pif.tx_packet_byte_ready) rdy_cnt++;
            if (pif.tx_bit_req && chk_en) begin
                obs_q.push_back(pif.tx_bit);
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL extra_bit: got bit %0d beyond expected stream", obs_q.size() - 1);
                end else begin
                    check($sformatf("bit%0d", obs_q.size() - 1), pif.tx_bit, exp_q.pop_front());
                end
            end
        end
    end

    // payload feeder
    initial begin
        pif.tx_packet_byte_valid = 1'b0;
        pif.tx_packet_byte = 8'h00;
        forever begin
            @(negedge clk);
            xfer = pif.tx_packet_byte_valid && pif.tx_packet_byte_ready;
            @(posedge clk);
            #1;
            if (xfer && byte_q.size() > 0) begin
                void'(byte_q.pop_front());
                hs_cnt++;
            end
            if (byte_q.size() > 0) begin
                pif.tx_packet_byte_valid = 1'b1;
                pif.tx_packet_byte = byte_q[0];
            end else begin
                pif.tx_packet_byte_valid = 1'b0;
                pif.tx_packet_byte = 8'h00;
            end
        end
    end

    task automatic push_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    task automatic exp_token(input logic [3:0] pid, input logic [10:0] addr);
        logic [4:0] c;
        push_bits({8'h00, ~pid, pid}, 8);
        push_bits({5'b00000, addr}, 11);
        c = 5'h1F;
        for (int i = 0; i < 11; i++) c = crc5_upd(c, addr[i]);
        for (int i = 4; i >= 0; i--) exp_q.push_back(~c[i]);
    endtask

    task automatic exp_data(input logic [3:0] pid);
        logic [15:0] c;
        push_bits({8'h00, ~pid, pid}, 8);
        c = 16'hFFFF;
        foreach (pay_q[k]) begin
            push_bits({8'h00, pay_q[k]}, 8);
            for (int i = 0; i < 8; i++) c = crc16_upd(c, pay_q[k][i]);
        end
        for (int i = 15; i >= 0; i--) exp_q.push_back(~c[i]);
    endtask

    task automatic start_pkt(input logic [3:0] pid, input logic [10:0] addr, input logic [9:0] len, input bit req_in_t);
        @(posedge clk);
        #1;
        pif.tx_packet_start = 1'b1;
        pif.tx_packet_pid = pid;
        pif.tx_packet_addr = addr;
        pif.tx_packet_len = len;
        pif.tx_bit_req = req_in_t;
        @(posedge clk);
        #1;
        pif.tx_packet_start = 1'b0;
        pif.tx_bit_req = 1'b0;
        check("tx_start_pulse", pif.tx_start, 1);
        check("tx_busy_after_start", pif.tx_busy, 1);
        obs_q.delete();
        chk_en = 1'b1;
    endtask

    task automatic req_bits(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 pif.tx_bit_req = 1'b1;
            @(posedge clk);
            #1 pif.tx_bit_req = 1'b0;
            if (i != n - 1) repeat (3) @(posedge clk);
        end
    endtask

    task automatic end_pkt(input string name);
        check({name, "_finish_r1"}, pif.tx_finish, 1);
        @(posedge clk);
        #1;
        check({name, "_busy_low_r2"}, pif.tx_busy, 0);
        check({name, "_bits_left"}, exp_q.size(), 0);
        chk_en = 1'b0;
    endtask

    // receiver-side decode of the observed stream: PID check nibble, field, CRC residual
    task automatic decode(input string name, input logic [3:0] pid, input int kind, input logic [10:0] addr, input int nbytes);
        logic [7:0] pb;
        logic [3:0] npid;
        logic [10:0] f;
        logic [4:0] c5;
        logic [15:0] c16;
        int n;
        n = (kind == 1) ? 24 : (kind == 2) ? (8 + 8 * nbytes + 16) : 8;
        npid = ~pid;
        check({name, "_rx_len"}, obs_q.size(), n);
        if (obs_q.size() == n) begin
            pb = '0;
            for (int i = 0; i < 8; i++) pb[i] = obs_q[i];
            check({name, "_rx_pid"}, pb[3:0], pid);
            check({name, "_rx_pid_chk"}, pb[7:4], npid);
            if (kind == 1) begin
                f = '0;
                c5 = 5'h1F;
                for (int i = 0; i < 11; i++) f[i] = obs_q[8 + i];
                for (int i = 8; i < 24; i++) c5 = crc5_upd(c5, obs_q[i]);
                check({name, "_rx_addr"}, f, addr);
                check({name, "_rx_crc5_residual"}, c5, 5'b01100);
            end else if (kind == 2) begin
                c16 = 16'hFFFF;
                for (int i = 8; i < n; i++) c16 = crc16_upd(c16, obs_q[i]);
                check({name, "_rx_crc16_residual"}, c16, 16'h800D);
            end
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pif.tx_packet_start = 1'b0;
        pif.tx_packet_pid = 4'h0;
        pif.tx_packet_addr = 11'h000;
        pif.tx_packet_len = 10'd0;
        pif.tx_bit_req = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_bit", pif.tx_bit, 0);
        check("rst_tx_busy", pif.tx_busy, 0);
        check("rst_tx_start", pif.tx_start, 0);
        check("rst_tx_finish", pif.tx_finish, 0);
        check("rst_tx_underrun", pif.tx_underrun, 0);
        check("rst_byte_ready", pif.tx_packet_byte_ready, 0);
        @(negedge clk) rst_n = 1'b1;

        // bit request while idle
        req_bits(1);
        @(posedge clk);
        #1;
        check("idle_req_tx_bit", pif.tx_bit, 0);
        check("idle_req_busy", pif.tx_busy, 0);

        // SETUP addr 0 endp 0 -> 2D 00 10, with a request in the accept cycle
        push_bits(16'h002D, 8);
        push_bits(16'h0000, 8);
        push_bits(16'h0010, 8);
        f0 = fin_cnt;
        start_pkt(4'b1101, 11'h000, 10'd0, 1'b1);
        req_bits(24);
        end_pkt("setup");
        check("setup_finish_once", fin_cnt - f0, 1);
        decode("setup", 4'b1101, 1, 11'h000, 0);

        // OUT token
        exp_token(4'b0001, 11'b10101100111);
        start_pkt(4'b0001, 11'b10101100111, 10'd0, 1'b0);
        req_bits(24);
        end_pkt("out");
        decode("out", 4'b0001, 1, 11'b10101100111, 0);

        // ACK: 0,1,0,0,1,0,1,1
        push_bits(16'h00D2, 8);
        r0 = rdy_cnt;
        start_pkt(4'b0010, 11'h000, 10'd0, 1'b0);
        req_bits(8);
        end_pkt("ack");
        check("ack_ready_never", rdy_cnt - r0, 0);
        decode("ack", 4'b0010, 0, 11'h000, 0);

        // DATA1 len 0: 4B then 16 zero CRC bits
        push_bits(16'h004B, 8);
        push_bits(16'h0000, 16);
        start_pkt(4'b1011, 11'h000, 10'd0, 1'b0);
        req_bits(24);
        end_pkt("data1_len0");
        decode("data1_len0", 4'b1011, 2, 11'h000, 0);

        // MDATA len 3, plus a start attempt while busy
        pay_q = '{8'h67, 8'h65, 8'h8A};
        byte_q = pay_q;
        h0 = hs_cnt;
        s0 = start_cnt;
        exp_data(4'b1111);
        start_pkt(4'b1111, 11'h000, 10'd3, 1'b0);
        req_bits(20);
        @(posedge clk);
        #1;
        pif.tx_packet_start = 1'b1;
        pif.tx_packet_pid = 4'b0010;
        @(posedge clk);
        #1 pif.tx_packet_start = 1'b0;
        req_bits(28);
        end_pkt("mdata");
        check("mdata_handshakes", hs_cnt - h0, 3);
        check("mdata_single_start", start_cnt - s0, 1);
        decode("mdata", 4'b1111, 2, 11'h000, 3);

        // DATA0 len 2 with byte 1 withheld -> underrun at request 17
        byte_q = '{8'hA5};
        h0 = hs_cnt;
        u0 = und_cnt;
        push_bits(16'h00C3, 8);
        push_bits(16'h00A5, 8);
        start_pkt(4'b0011, 11'h000, 10'd2, 1'b0);
        req_bits(16);
        chk_en = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1 pif.tx_bit_req = 1'b1;
        @(posedge clk);
        #1 pif.tx_bit_req = 1'b0;
        check("urun_pulse", pif.tx_underrun, 1);
        check("urun_finish", pif.tx_finish, 1);
        @(posedge clk);
        #1;
        check("urun_busy_low", pif.tx_busy, 0);
        check("urun_pulse_once", und_cnt - u0, 1);
        check("urun_bytes_taken", hs_cnt - h0, 1);
        check("urun_bits_left", exp_q.size(), 0);
        check("urun_ready_low", pif.tx_packet_byte_ready, 0);

        // reset mid-FIELD, then a clean packet
        exp_token(4'b0001, 11'h123);
        start_pkt(4'b0001, 11'h123, 10'd0, 1'b0);
        req_bits(12);
        f0 = fin_cnt;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx_bit", pif.tx_bit, 0);
        check("midrst_busy", pif.tx_busy, 0);
        check("midrst_finish", pif.tx_finish, 0);
        check("midrst_underrun", pif.tx_underrun, 0);
        check("midrst_start", pif.tx_start, 0);
        chk_en = 1'b0;
        exp_q.delete();
        byte_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_finish", fin_cnt - f0, 0);
        exp_token(4'b1001, 11'h03A);
        start_pkt(4'b1001, 11'h03A, 10'd0, 1'b0);
        req_bits(24);
        end_pkt("after_rst");
        check("after_rst_finish_once", fin_cnt - f0, 1);
        decode("after_rst", 4'b1001, 1, 11'h03A, 0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
